// File: rtl/seq_det_arbiter_if.sv
// Request/result handshake plus serial detector link for seq_det_arbiter.
// master = arbiter side; slave = requesters and detector side.
interface seq_det_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
);
  logic             REQ0;
  logic             REQ1;
  logic [WIDTH-1:0] DATA0;
  logic [WIDTH-1:0] DATA1;
  logic             GNT0;
  logic             GNT1;
  logic             DONE0;
  logic             DONE1;
  logic [CNT_W-1:0] RESULT;
  logic             BUSY;
  logic             DET_RST;
  logic             DET_IN;
  logic             DET_OUT;

  modport master (
    input  REQ0, REQ1, DATA0, DATA1, DET_OUT,
    output GNT0, GNT1, DONE0, DONE1, RESULT, BUSY, DET_RST, DET_IN
  );

  modport slave (
    output REQ0, REQ1, DATA0, DATA1, DET_OUT,
    input  GNT0, GNT1, DONE0, DONE1, RESULT, BUSY, DET_RST, DET_IN
  );
endinterface

// File: rtl/seq_det_arbiter.sv
// Round-robin share of one serial sequence detector between two requesters; DONE at WIDTH+DET_LAT+2
// cycles after the request edge, requests wait (held REQ) while a job is in flight, all outputs registered.
module seq_det_arbiter #(
  parameter int WIDTH   = 8,
  parameter int DET_LAT = 1,
  parameter int CNT_W   = 5
) (
  input logic              CLK,
  input logic              RST,
  seq_det_arbiter_if.master bus
);
  localparam int LAST_K = WIDTH + DET_LAT - 1;
  localparam int KW     = $clog2(WIDTH + DET_LAT + 1);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, REPORT} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             busy_q, busy_d;
  logic             det_rst_q, det_rst_d;
  logic             det_in_q, det_in_d;
  logic             hit;

  // Only hits that can be caused by this job's bits are counted.
  assign hit = bus.DET_OUT && (k_q >= KW'(DET_LAT));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    shreg_d      = shreg_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    busy_d       = 1'b0;
    det_rst_d    = 1'b0;
    det_in_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          owner_d   = (bus.REQ0 && bus.REQ1) ? ~last_owner_q : bus.REQ1;
          shreg_d   = owner_d ? bus.DATA1 : bus.DATA0;
          gnt0_d    = ~owner_d;
          gnt1_d    = owner_d;
          det_rst_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = CLR;
        end
      end
      CLR: begin
        cnt_d    = '0;
        k_d      = '0;
        det_in_d = shreg_q[WIDTH-1];
        shreg_d  = shreg_q << 1;
        busy_d   = 1'b1;
        state_d  = SHIFT;
      end
      SHIFT: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CNT_W'(hit);
        if (k_q == KW'(LAST_K)) begin
          result_d = cnt_q + CNT_W'(hit);
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          state_d  = REPORT;
        end else begin
          // Register shifts in zeros, so bits past WIDTH drive DET_IN low.
          k_d      = k_q + 1'b1;
          det_in_d = shreg_q[WIDTH-1];
          shreg_d  = shreg_q << 1;
        end
      end
      REPORT: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      shreg_q      <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
      det_rst_q    <= 1'b0;
      det_in_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      shreg_q      <= shreg_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy_q       <= busy_d;
      det_rst_q    <= det_rst_d;
      det_in_q     <= det_in_d;
    end
  end

  assign bus.GNT0    = gnt0_q;
  assign bus.GNT1    = gnt1_q;
  assign bus.DONE0   = done0_q;
  assign bus.DONE1   = done1_q;
  assign bus.RESULT  = result_q;
  assign bus.BUSY    = busy_q;
  assign bus.DET_RST = det_rst_q;
  assign bus.DET_IN  = det_in_q;
endmodule

// File: tb/tb_seq_det_arbiter.sv
// Bench for seq_det_arbiter: default instance plus a WIDTH=4/DET_LAT=3 instance, each with an
// overlapping "11" Moore detector model; expected events/samples are queued and checked by a monitor.
module tb_seq_det_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic force_hi = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  seq_det_arbiter_if #(.WIDTH(8), .CNT_W(5)) bus0 ();
  seq_det_arbiter_if #(.WIDTH(4), .CNT_W(3)) bus1 ();

  seq_det_arbiter #(.WIDTH(8), .DET_LAT(1), .CNT_W(5)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  seq_det_arbiter #(.WIDTH(4), .DET_LAT(3), .CNT_W(3)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  // Detector models: latency 1 and latency 3, cleared by DET_RST.
  logic       prev0 = 1'b0;
  logic       hit0  = 1'b0;
  logic       prev1 = 1'b0;
  logic [2:0] h1    = '0;
  always @(posedge CLK) begin
    if (bus0.DET_RST) begin
      prev0 <= 1'b0;
      hit0  <= 1'b0;
    end else begin
      prev0 <= bus0.DET_IN;
      hit0  <= prev0 & bus0.DET_IN;
    end
    if (bus1.DET_RST) begin
      prev1 <= 1'b0;
      h1    <= '0;
    end else begin
      prev1 <= bus1.DET_IN;
      h1    <= {h1[1:0], prev1 & bus1.DET_IN};
    end
  end
  assign bus0.DET_OUT = hit0 | force_hi;
  assign bus1.DET_OUT = h1[2];

  logic [7:0] obs0, obs1;
  assign obs0 = {bus0.RESULT == '0, bus0.DET_IN, bus0.DET_RST, bus0.BUSY,
                 bus0.DONE1, bus0.DONE0, bus0.GNT1, bus0.GNT0};
  assign obs1 = {bus1.RESULT == '0, bus1.DET_IN, bus1.DET_RST, bus1.BUSY,
                 bus1.DONE1, bus1.DONE0, bus1.GNT1, bus1.GNT0};

  typedef struct {int dut; int cyc; bit is_done; bit id; int res;} ev_t;
  typedef struct {int dut; int cyc; int sig; bit val;} smp_t;
  ev_t  ev_q[$];
  smp_t smp_q[$];
  string sig_nm[8] = '{"GNT0", "GNT1", "DONE0", "DONE1", "BUSY", "DET_RST", "DET_IN", "RESULT_ZERO"};

  task automatic check(input string nm, input int d, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d got=%0d exp=%0d", nm, d, cyc, got, exp);
  endtask

  task automatic exp_sig(input int d, input int c, input int s, input bit v);
    smp_t e;
    e = '{d, c, s, v};
    smp_q.push_back(e);
  endtask

  task automatic exp_ev(input int d, input int c, input bit is_done, input bit id, input int res);
    ev_t e;
    e = '{d, c, is_done, id, res};
    ev_q.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, away from DUT updates.
  logic [7:0] m_o;
  int         m_r;
  int         m_idx;
  ev_t        m_e;
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      m_o = (d == 0) ? obs0 : obs1;
      m_r = (d == 0) ? int'(bus0.RESULT) : int'(bus1.RESULT);
      for (int i = smp_q.size() - 1; i >= 0; i--) begin
        if (smp_q[i].dut == d && smp_q[i].cyc == cyc) begin
          check(sig_nm[smp_q[i].sig], d, int'(m_o[smp_q[i].sig]), int'(smp_q[i].val));
          smp_q.delete(i);
        end
      end
      if (|m_o[3:0]) begin
        m_idx = -1;
        for (int i = 0; i < ev_q.size(); i++) begin
          if (ev_q[i].dut == d) begin
            m_idx = i;
            break;
          end
        end
        if (m_idx < 0) begin
          n_chk++;
          $display("FAIL unexpected_event dut%0d cyc=%0d got=%b exp=none", d, cyc, m_o[3:0]);
        end else begin
          m_e = ev_q[m_idx];
          ev_q.delete(m_idx);
          check("ev_kind_done", d, int'(m_o[2] | m_o[3]), int'(m_e.is_done));
          check("ev_owner", d, int'(m_o[1] | m_o[3]), int'(m_e.id));
          check("ev_cycle", d, cyc, m_e.cyc);
          if (m_e.is_done) check("RESULT", d, m_r, m_e.res);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // fmask bit 0 forces DET_OUT in the CLR cycle, bit 1+k in SHIFT cycle k.
  task automatic job(input bit id, input logic [7:0] dat, input int res,
                     input logic [15:0] fmask, input int abort_at);
    int s;
    s = cyc;
    if (id) begin
      bus0.REQ1  = 1'b1;
      bus0.DATA1 = dat;
    end else begin
      bus0.REQ0  = 1'b1;
      bus0.DATA0 = dat;
    end
    exp_sig(0, s, 4, 1'b0);
    exp_ev(0, s + 1, 1'b0, id, 0);
    exp_sig(0, s + 1, 5, 1'b1);
    exp_sig(0, s + 2, 5, 1'b0);
    if (abort_at == 0) begin
      exp_ev(0, s + 11, 1'b1, id, res);
      for (int j = 1; j <= 11; j++) exp_sig(0, s + j, 4, 1'b1);
      exp_sig(0, s + 12, 4, 1'b0);
      for (int k = 0; k < 9; k++) exp_sig(0, s + 2 + k, 6, (k < 8) ? dat[7 - k] : 1'b0);
    end else begin
      for (int j = 1; j <= abort_at; j++) exp_sig(0, s + j, 4, 1'b1);
      for (int k = 0; k <= abort_at - 2; k++) exp_sig(0, s + 2 + k, 6, dat[7 - k]);
      for (int sg = 0; sg < 7; sg++) exp_sig(0, s + abort_at + 1, sg, 1'b0);
      exp_sig(0, s + abort_at + 1, 7, 1'b1);
      exp_sig(0, s + 11, 2 + int'(id), 1'b0);
    end
    for (int j = 1; j <= 13; j++) begin
      tick();
      force_hi = fmask[j-1];
      if (j == 1) begin
        bus0.REQ0 = 1'b0;
        bus0.REQ1 = 1'b0;
      end
      if (abort_at != 0 && j == abort_at) RST = 1'b1;
      if (abort_at != 0 && j == abort_at + 1) RST = 1'b0;
    end
    force_hi = 1'b0;
  endtask

  initial begin
    int s;
    logic [7:0] dj;
    bus0.REQ0  = 1'b1;
    bus0.REQ1  = 1'b1;
    bus0.DATA0 = 8'hFF;
    bus0.DATA1 = 8'h55;
    bus1.REQ0  = 1'b0;
    bus1.REQ1  = 1'b0;
    bus1.DATA0 = '0;
    bus1.DATA1 = '0;

    // Reset held two cycles with both requests high.
    for (int c = 1; c <= 2; c++) begin
      for (int sg = 0; sg < 7; sg++) exp_sig(0, c, sg, 1'b0);
      exp_sig(0, c, 7, 1'b1);
    end
    tick();
    tick();
    RST = 1'b0;

    // Contention: alternating owners, REQs dropped mid third job.
    s = cyc;
    for (int n = 0; n < 3; n++) begin
      exp_ev(0, s + 1 + 12 * n, 1'b0, n[0], 0);
      exp_ev(0, s + 11 + 12 * n, 1'b1, n[0], n[0] ? 0 : 7);
      for (int j = 1; j <= 11; j++) exp_sig(0, s + j + 12 * n, 4, 1'b1);
      exp_sig(0, s + 12 + 12 * n, 4, 1'b0);
      dj = n[0] ? 8'h55 : 8'hFF;
      for (int k = 0; k < 8; k++) exp_sig(0, s + 2 + k + 12 * n, 6, dj[7 - k]);
    end
    exp_sig(0, s + 37, 4, 1'b0);
    while (cyc < s + 28) tick();
    bus0.REQ0 = 1'b0;
    bus0.REQ1 = 1'b0;
    while (cyc < s + 38) tick();

    job(1'b0, 8'hEC, 3, 16'h0000, 0);
    job(1'b0, 8'h00, 0, 16'h0003, 0);
    job(1'b0, 8'h00, 1, 16'h0200, 0);
    job(1'b1, 8'hA5, 0, 16'h0000, 5);
    job(1'b1, 8'hC0, 1, 16'h0000, 0);

    // WIDTH=4, DET_LAT=3 instance.
    s = cyc;
    bus1.REQ0  = 1'b1;
    bus1.DATA0 = 4'hF;
    exp_ev(1, s + 1, 1'b0, 1'b0, 0);
    exp_ev(1, s + 9, 1'b1, 1'b0, 3);
    exp_sig(1, s + 1, 5, 1'b1);
    for (int j = 1; j <= 9; j++) exp_sig(1, s + j, 4, 1'b1);
    exp_sig(1, s + 10, 4, 1'b0);
    for (int k = 0; k < 5; k++) exp_sig(1, s + 2 + k, 6, (k < 4) ? 1'b1 : 1'b0);
    tick();
    bus1.REQ0 = 1'b0;
    for (int j = 0; j < 12; j++) tick();

    foreach (smp_q[i]) begin
      n_chk++;
      $display("FAIL unchecked_sample %s dut%0d at cyc=%0d got=none exp=%0d",
               sig_nm[smp_q[i].sig], smp_q[i].dut, smp_q[i].cyc, smp_q[i].val);
    end
    foreach (ev_q[i]) begin
      n_chk++;
      $display("FAIL missing_event dut%0d got=none exp=%s at cyc=%0d",
               ev_q[i].dut, ev_q[i].is_done ? "DONE" : "GNT", ev_q[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
